debouncer_multi: RTL and testbench

DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

---
 rtl/debouncer_multi_if.sv | 11 +
 rtl/debouncer_multi.sv | 53 +++++
 tb/tb_debouncer_multi.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/debouncer_multi_if.sv
// debouncer_multi_if: raw channel inputs, count enable and debounced outputs of debouncer_multi
interface debouncer_multi_if #(parameter int CHANNELS = 2);
    logic                ce;
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                changed;
    modport master (output ce, in, input out, rise, fall, changed);
    modport slave (input ce, in, output out, rise, fall, changed);
endinterface

// File: rtl/debouncer_multi.sv
// debouncer_multi: per-channel synchronizer plus stability counter; out follows in after a full quiet window
module debouncer_multi #(
    parameter int                  CHANNELS     = 2,
    parameter int                  COUNTER_BITS = 5,
    parameter int                  SYNC_STAGES  = 2,
    parameter logic [CHANNELS-1:0] RESET_VALUE  = '0
) (
    input  logic              clk,
    input  logic              reset,
    debouncer_multi_if.slave  bus
);
    logic [SYNC_STAGES-1:0][CHANNELS-1:0]  sync_q, sync_d;
    logic [CHANNELS-1:0][COUNTER_BITS-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0] out_q, out_d, rise_q, rise_d, fall_q, fall_d;
    logic [CHANNELS-1:0] s, at_max, flip;
    logic                changed_q, changed_d;
    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.in};
    assign s      = sync_q[SYNC_STAGES-1];
    for (genvar g = 0; g < CHANNELS; g++) begin : g_max
        assign at_max[g] = &cnt_q[g];
    end
    // a channel commits only on the qualifying edge that finds its counter already at MAX
    assign flip      = (s ^ out_q) & at_max & {CHANNELS{bus.ce}};
    assign out_d     = out_q ^ flip;
    assign rise_d    = flip & s;
    assign fall_d    = flip & ~s;
    assign changed_d = |flip;
    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            cnt_d[i] = (s[i] == out_q[i] || flip[i]) ? '0 : bus.ce ? cnt_q[i] + 1'b1 : cnt_q[i];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= {SYNC_STAGES{RESET_VALUE}};
            cnt_q     <= '0;
            out_q     <= RESET_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end
    assign bus.out     = out_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.changed = changed_q;
endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: random and directed stimulus on two debouncers (reset values 00 and 10) against a behavioural model
module tb_debouncer_multi;
    localparam int CH   = 2;
    localparam int CB   = 5;
    localparam int SS   = 2;
    localparam int WIN  = 1 << CB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] in_v = '0;
    logic          ce_v = 1'b1;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    debouncer_multi_if #(.CHANNELS(CH)) if_a ();
    debouncer_multi_if #(.CHANNELS(CH)) if_b ();
    assign if_a.in = in_v;
    assign if_b.in = in_v;
    assign if_a.ce = ce_v;
    assign if_b.ce = ce_v;

    debouncer_multi #(.CHANNELS(CH), .COUNTER_BITS(CB), .SYNC_STAGES(SS), .RESET_VALUE(2'b00))
        u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    debouncer_multi #(.CHANNELS(CH), .COUNTER_BITS(CB), .SYNC_STAGES(SS), .RESET_VALUE(2'b10))
        u_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    // model: input seen SS edges late; out flips after WIN consecutive ce-qualified disagreeing edges
    logic [CH-1:0] rv [2];
    logic [CH-1:0] dl [2][SS];
    logic [CH-1:0] m_out [2];
    logic [CH-1:0] e_rise [2];
    logic [CH-1:0] e_fall [2];
    logic          e_chg [2];
    int            streak [2][CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic [CH-1:0] x);
        logic [CH-1:0] seen;
        for (int k = 0; k < 2; k++) begin
            e_rise[k] = '0;
            e_fall[k] = '0;
            if (r) begin
                for (int j = 0; j < SS; j++) dl[k][j] = rv[k];
                m_out[k] = rv[k];
                for (int i = 0; i < CH; i++) streak[k][i] = 0;
            end else begin
                seen = dl[k][SS-1];
                for (int i = 0; i < CH; i++) begin
                    if (seen[i] == m_out[k][i]) streak[k][i] = 0;
                    else if (c) begin
                        streak[k][i]++;
                        if (streak[k][i] == WIN) begin
                            streak[k][i] = 0;
                            m_out[k][i] = seen[i];
                            if (seen[i]) e_rise[k][i] = 1'b1;
                            else e_fall[k][i] = 1'b1;
                        end
                    end
                end
                for (int j = SS - 1; j > 0; j--) dl[k][j] = dl[k][j-1];
                dl[k][0] = x;
            end
            e_chg[k] = |(e_rise[k] | e_fall[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(reset, ce_v, in_v);
        #1;
        check("a_out", 32'(if_a.out), 32'(m_out[0]));
        check("a_rise", 32'(if_a.rise), 32'(e_rise[0]));
        check("a_fall", 32'(if_a.fall), 32'(e_fall[0]));
        check("a_changed", 32'(if_a.changed), 32'(e_chg[0]));
        check("b_out", 32'(if_b.out), 32'(m_out[1]));
        check("b_rise", 32'(if_b.rise), 32'(e_rise[1]));
        check("b_fall", 32'(if_b.fall), 32'(e_fall[1]));
        check("b_changed", 32'(if_b.changed), 32'(e_chg[1]));
    endtask

    initial begin
        int            lat;
        int            mode;
        int            len;
        logic [CH-1:0] lvl;
        rv[0] = 2'b00;
        rv[1] = 2'b10;
        tick();
        tick();
        check("reset_out_a", 32'(if_a.out), 32'h0);
        check("reset_out_b", 32'(if_b.out), 32'h2);
        reset = 1'b0;
        // clean rising edge on channel 0; u_b sees rise on 0 and fall on 1 together
        in_v = 2'b01;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (lat == 0 && if_a.rise[0]) lat = n;
        end
        check("clean_latency", 32'(lat), 32'd34);
        // glitch restarts the window
        in_v = 2'b00;
        for (int n = 0; n < 60; n++) tick();
        in_v[0] = 1'b1;
        for (int n = 0; n < 20; n++) tick();
        in_v[0] = 1'b0;
        tick();
        in_v[0] = 1'b1;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (lat == 0 && if_a.rise[0]) lat = n;
        end
        check("glitch_latency", 32'(lat), 32'd34);
        // reset in mid-count, then full latency after release
        in_v = 2'b11;
        for (int n = 0; n < 60; n++) tick();
        in_v = 2'b00;
        for (int n = 0; n < 60; n++) tick();
        in_v = 2'b11;
        for (int n = 0; n < 19; n++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (lat == 0 && if_a.rise == 2'b11) lat = n;
        end
        check("post_reset_latency", 32'(lat), 32'd34);
        // randomized phases: level holds, short glitches, ce patterns, sporadic resets
        for (int p = 0; p < 80; p++) begin
            mode = $urandom_range(0, 2);
            len  = $urandom_range(1, 90);
            lvl  = CH'($urandom);
            for (int c = 0; c < len; c++) begin
                in_v  = (c == len / 2 && $urandom_range(0, 3) == 0) ? lvl ^ CH'($urandom_range(1, 3)) : lvl;
                ce_v  = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 0) : 1'($urandom);
                reset = ($urandom_range(0, 149) == 0);
                tick();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
